// File: rtl/ahbmtx_l2_in_stg_if.sv
// ahbmtx_l2_in_stg_if: bundle between an upstream AHB master port, the L2
// matrix input stage and that port's address decoder.
//   Master side : HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS,
//                 HMASTLOCKS, HREADYS in; HREADYOUTS, HRESPS back.
//   Decoder side: sel_op, addr_op, trans_op, write_op, size_op, burst_op,
//                 prot_op, mastlock_op, held_tran_op out; active_op,
//                 readyout_op, resp_op back.
// Modports: slave  = the input stage itself,
//           master = the environment (upstream master + decoder).
interface ahbmtx_l2_in_stg_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned PROT_W = 4
);
  logic              HSELS;
  logic [ADDR_W-1:0] HADDRS;
  logic [1:0]        HTRANSS;
  logic              HWRITES;
  logic [2:0]        HSIZES;
  logic [2:0]        HBURSTS;
  logic [PROT_W-1:0] HPROTS;
  logic              HMASTLOCKS;
  logic              HREADYS;
  logic              HREADYOUTS;
  logic [1:0]        HRESPS;

  logic              sel_op;
  logic [ADDR_W-1:0] addr_op;
  logic [1:0]        trans_op;
  logic              write_op;
  logic [2:0]        size_op;
  logic [2:0]        burst_op;
  logic [PROT_W-1:0] prot_op;
  logic              mastlock_op;
  logic              held_tran_op;
  logic              active_op;
  logic              readyout_op;
  logic [1:0]        resp_op;

  modport slave (
    input  HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS,
           HMASTLOCKS, HREADYS, active_op, readyout_op, resp_op,
    output HREADYOUTS, HRESPS, sel_op, addr_op, trans_op, write_op, size_op,
           burst_op, prot_op, mastlock_op, held_tran_op
  );

  modport master (
    output HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS,
           HMASTLOCKS, HREADYS, active_op, readyout_op, resp_op,
    input  HREADYOUTS, HRESPS, sel_op, addr_op, trans_op, write_op, size_op,
           burst_op, prot_op, mastlock_op, held_tran_op
  );
endinterface

// File: rtl/ahbmtx_l2_in_stg.sv
// ahbmtx_l2_in_stg: slave-port input stage of the L2 AHB bus matrix.
// Forwards the live address phase straight to the decoder when the target
// output stage takes it; otherwise captures it and replays it from a holding
// register while stalling the master (HREADYOUTS=0).
// Ports:
//   HCLK    - AHB clock
//   HRESETn - asynchronous active-low reset
//   bus     - ahbmtx_l2_in_stg_if.slave (master address phase in, response
//             out; decoder address phase out, decoder response in)
// Optional build macro: AHBMTX_L2_IN_STG_SEQ2NSEQ_EN - a replayed SEQ beat is
// presented as NONSEQ/INCR since arbitration may have split the burst.
module ahbmtx_l2_in_stg #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned PROT_W = 4
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  ahbmtx_l2_in_stg_if.slave    bus
);

  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;
  localparam logic [2:0] BURST_INCR   = 3'b001;
  localparam logic [1:0] RESP_OKAY    = 2'b00;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [1:0]        trans;
    logic              write;
    logic [2:0]        size;
    logic [2:0]        burst;
    logic [PROT_W-1:0] prot;
    logic              mastlock;
  } addr_phase_t;

  state_e      state_q;
  addr_phase_t hold_q;
  addr_phase_t live_c;
  addr_phase_t out_c;
  logic        trans_valid_c;
  logic        accept_c;

  // Only NONSEQ/SEQ with the layer ready are real transfers.
  assign trans_valid_c = bus.HSELS & bus.HTRANSS[1] & bus.HREADYS;
  assign accept_c      = bus.active_op & bus.readyout_op;

  assign live_c = '{addr:     bus.HADDRS,
                    trans:    bus.HTRANSS,
                    write:    bus.HWRITES,
                    size:     bus.HSIZES,
                    burst:    bus.HBURSTS,
                    prot:     bus.HPROTS,
                    mastlock: bus.HMASTLOCKS};

  // Pending-transfer FSM and holding register. A live transfer seen while
  // pending cannot occur on a compliant layer and is ignored.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (trans_valid_c) begin
            hold_q <= live_c;
            if (!accept_c) state_q <= ST_PEND;
          end
        end
        ST_PEND: begin
          if (accept_c) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Address-phase source select toward the decoder.
  always_comb begin
    out_c = live_c;
    if (state_q == ST_PEND) begin
      out_c = hold_q;
`ifdef AHBMTX_L2_IN_STG_SEQ2NSEQ_EN
      if (hold_q.trans == TRANS_SEQ) begin
        out_c.trans = TRANS_NONSEQ;
        out_c.burst = BURST_INCR;
      end
`endif
    end
  end

  assign bus.held_tran_op = (state_q == ST_PEND);
  assign bus.sel_op       = (state_q == ST_PEND) ? 1'b1 : bus.HSELS;
  assign bus.addr_op      = out_c.addr;
  assign bus.trans_op     = out_c.trans;
  assign bus.write_op     = out_c.write;
  assign bus.size_op      = out_c.size;
  assign bus.burst_op     = out_c.burst;
  assign bus.prot_op      = out_c.prot;
  assign bus.mastlock_op  = out_c.mastlock;

  // The master is stalled with OKAY for as long as a held transfer waits.
  assign bus.HREADYOUTS = (state_q == ST_PEND) ? 1'b0 : bus.readyout_op;
  assign bus.HRESPS     = (state_q == ST_PEND) ? RESP_OKAY : bus.resp_op;

endmodule
